multi_port_free_list: RTL and testbench

- Parametrised successor to the single-port register free list: a LUT-RAM circular buffer of physical register IDs.
- Up to POP_PORTS allocations and PUSH_PORTS releases per cycle, plus a multi-entry rollback of the read pointer.
- Sits between the renamer (pop = allocate, rollback = undo speculative allocations) and retire/commit (push = free).
- Lets the rename stage go superscalar.

---
 rtl/multi_port_free_list_pkg.sv | 12 +
 rtl/multi_port_free_list_if.sv | 32 +++
 rtl/multi_port_free_list_rank_encoder.sv | 22 ++
 rtl/multi_port_free_list.sv | 161 ++++++++++++++++
 tb/tb_multi_port_free_list.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_port_free_list_pkg.sv
// Shared types for the multi-port physical register free list.
// Physical ID type and init-sequence state encoding.
package cva5_types;
    localparam int PHYS_ID_WIDTH = 6;

    typedef logic [PHYS_ID_WIDTH-1:0] phys_id_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } free_list_init_state_t;
endpackage

// File: rtl/multi_port_free_list_if.sv
// Renamer/retire-facing bundle of the multi-port free list.
// master = allocator/releaser side, slave = the free list itself.
interface multi_port_free_list_if #(
    parameter int DATA_WIDTH = 6,
    parameter int FIFO_DEPTH = 32,
    parameter int POP_PORTS  = 2,
    parameter int PUSH_PORTS = 2
);
    localparam int DEPTH_P2 = 1 << $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(DEPTH_P2) + 1;
    localparam int RB_W     = $clog2(POP_PORTS + 1);

    logic [POP_PORTS-1:0]             pop_request;
    logic [POP_PORTS-1:0]             pop_valid;
    logic [POP_PORTS*DATA_WIDTH-1:0]  pop_data;
    logic [PUSH_PORTS-1:0]            push;
    logic [PUSH_PORTS*DATA_WIDTH-1:0] push_data;
    logic [RB_W-1:0]                  rollback_count;
    logic [CNT_W-1:0]                 count;
    logic                             full;
    logic                             init_done;

    modport master (
        output pop_request, push, push_data, rollback_count,
        input  pop_valid, pop_data, count, full, init_done
    );

    modport slave (
        input  pop_request, push, push_data, rollback_count,
        output pop_valid, pop_data, count, full, init_done
    );
endinterface

// File: rtl/multi_port_free_list_rank_encoder.sv
// Per-bit rank (number of set bits below each position) and total popcount.
// Used to compact sparse push strobes and to count pops.
module free_list_rank_encoder #(
    parameter int N = 2,
    localparam int W = $clog2(N + 1)
) (
    input  logic [N-1:0]        strobe,
    output logic [N-1:0][W-1:0] rank,
    output logic [W-1:0]        total
);
    logic [W-1:0] acc;

    always_comb begin
        acc  = '0;
        rank = '0;
        for (int i = 0; i < N; i++) begin
            rank[i] = acc;
            acc     = acc + W'(strobe[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/multi_port_free_list.sv
// Multi-port circular free list of physical register IDs (LUT-RAM, no RAM reset).
// Optional FREE_LIST_INIT_EN preloads INIT_BASE+i after reset via an INIT -> RUN FSM.
//   state | meaning
//   INIT  | filling RAM with INIT_BASE+i, PUSH_PORTS entries per cycle; inputs ignored
//   RUN   | normal allocate/release/rollback operation
module multi_port_free_list
    import cva5_types::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int FIFO_DEPTH = 32,
    parameter int POP_PORTS  = 2,
    parameter int PUSH_PORTS = 2,
    parameter int INIT_BASE  = 32
) (
    input logic                   clk,
    input logic                   rst,
    multi_port_free_list_if.slave fl
);
    localparam int DEPTH_P2 = 1 << $clog2(FIFO_DEPTH);
    localparam int IDX_W    = (DEPTH_P2 > 1) ? $clog2(DEPTH_P2) : 1;
    localparam int CNT_W    = $clog2(DEPTH_P2) + 1;
    localparam int POP_RW   = $clog2(POP_PORTS + 1);
    localparam int PUSH_RW  = $clog2(PUSH_PORTS + 1);

    if (POP_PORTS < 1 || POP_PORTS > 4 || PUSH_PORTS < 1 || PUSH_PORTS > 4 || INIT_BASE < 0)
        $error("multi_port_free_list: unsupported parameter set");

    logic [DATA_WIDTH-1:0] ram [DEPTH_P2];

    logic [IDX_W-1:0]  read_index, write_index;
    logic [CNT_W-1:0]  count_q, count_next;
    logic [CNT_W:0]    cnt_sum;
    logic              running;

    logic [PUSH_PORTS-1:0]              push_eff;
    logic [PUSH_PORTS-1:0][PUSH_RW-1:0] push_rank;
    logic [PUSH_RW-1:0]                 npush;
    logic [DATA_WIDTH-1:0]              wr_data [PUSH_PORTS];

    logic [POP_PORTS-1:0]             pop_eff;
    logic [POP_PORTS-1:0][POP_RW-1:0] pop_rank;
    logic [POP_RW-1:0]                npop;
    logic [POP_RW-1:0]                rollback_eff;

`ifdef FREE_LIST_INIT_EN
    localparam int INIT_CYCLES = (DEPTH_P2 + PUSH_PORTS - 1) / PUSH_PORTS;
    localparam int CTR_W       = $clog2(INIT_CYCLES + 1);

    free_list_init_state_t state, state_next;
    logic [CTR_W-1:0]      init_ctr, init_ctr_next;
    logic [PUSH_PORTS-1:0] init_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_ctr <= CTR_W'(INIT_CYCLES - 1);
        end else begin
            state    <= state_next;
            init_ctr <= init_ctr_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_ctr_next = init_ctr;
        case (state)
            INIT: begin
                if (init_ctr == '0) state_next = RUN;
                else init_ctr_next = init_ctr - CTR_W'(1);
            end
            RUN: state_next = RUN;
        endcase
    end

    assign running = (state == RUN);

    // Last INIT beat may be partial when DEPTH_P2 is not a multiple of PUSH_PORTS.
    always_comb begin
        init_we = '0;
        for (int j = 0; j < PUSH_PORTS; j++)
            init_we[j] = ({1'b0, count_q} + (CNT_W+1)'(j)) < (CNT_W+1)'(DEPTH_P2);
    end

    always_comb begin
        for (int j = 0; j < PUSH_PORTS; j++) begin
            wr_data[j] = running ? fl.push_data[j*DATA_WIDTH +: DATA_WIDTH]
                                 : DATA_WIDTH'(INIT_BASE + int'(count_q) + j);
        end
    end

    assign push_eff = running ? fl.push : init_we;

    a_idle_in_init: assert property (@(posedge clk) disable iff (rst)
        !running |-> (fl.push == '0 && fl.pop_request == '0 && fl.rollback_count == '0));
`else
    assign running  = 1'b1;
    assign push_eff = fl.push;

    always_comb begin
        for (int j = 0; j < PUSH_PORTS; j++)
            wr_data[j] = fl.push_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
`endif

    assign pop_eff      = fl.pop_request & {POP_PORTS{running}};
    assign rollback_eff = running ? fl.rollback_count : '0;

    free_list_rank_encoder #(.N(PUSH_PORTS)) push_enc (
        .strobe (push_eff),
        .rank   (push_rank),
        .total  (npush)
    );

    free_list_rank_encoder #(.N(POP_PORTS)) pop_enc (
        .strobe (pop_eff),
        .rank   (pop_rank),
        .total  (npop)
    );

    // One extra bit so overflow/underflow is visible to the legality check.
    assign cnt_sum    = {1'b0, count_q} + (CNT_W+1)'(npush) + (CNT_W+1)'(rollback_eff)
                        - (CNT_W+1)'(npop);
    assign count_next = cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_index  <= '0;
            write_index <= '0;
            count_q     <= '0;
        end else begin
            read_index  <= read_index + IDX_W'(npop) - IDX_W'(rollback_eff);
            write_index <= write_index + IDX_W'(npush);
            count_q     <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < PUSH_PORTS; j++) begin
            if (!rst && push_eff[j])
                ram[IDX_W'(write_index + IDX_W'(push_rank[j]))] <= wr_data[j];
        end
    end

    for (genvar k = 0; k < POP_PORTS; k++) begin : g_pop
        assign fl.pop_data[k*DATA_WIDTH +: DATA_WIDTH] = ram[IDX_W'(read_index + IDX_W'(k))];
        assign fl.pop_valid[k] = running && (count_q > CNT_W'(k));

        a_pop_prefix: assert property (@(posedge clk) disable iff (rst)
            fl.pop_request[k] |-> (pop_rank[k] == POP_RW'(k)));
    end

    assign fl.count     = count_q;
    assign fl.full      = (count_q == CNT_W'(DEPTH_P2));
    assign fl.init_done = running;

    a_pop_valid: assert property (@(posedge clk) disable iff (rst)
        (fl.pop_request & ~fl.pop_valid) == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        cnt_sum <= (CNT_W+1)'(DEPTH_P2));
endmodule

// File: tb/tb_multi_port_free_list.sv
// Directed bench for multi_port_free_list (DEPTH 32, 2 pop / 2 push ports).
// Build with FREE_LIST_INIT_EN to exercise the init sequence instead of the empty-start flow.
module tb_multi_port_free_list;
    import cva5_types::*;

    localparam int DW    = 6;
    localparam int DEPTH = 32;
    localparam int NPOP  = 2;
    localparam int NPUSH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_port_free_list_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                              .POP_PORTS(NPOP), .PUSH_PORTS(NPUSH)) fl_if ();

    multi_port_free_list #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .POP_PORTS(NPOP),
                           .PUSH_PORTS(NPUSH), .INIT_BASE(32)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if.slave)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int slice(input int k);
        phys_id_t v;
        v = fl_if.pop_data[k*DW +: DW];
        return int'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fl_if.pop_request    = '0;
        fl_if.push           = '0;
        fl_if.push_data      = '0;
        fl_if.rollback_count = '0;
    endtask

    task automatic drive_push(input logic [1:0] strobe, input int d0, input int d1);
        fl_if.push      = strobe;
        fl_if.push_data = {DW'(d1), DW'(d0)};
    endtask

`ifdef FREE_LIST_INIT_EN
    task automatic wait_init(input string tag, input int exp_cycles);
        int cycles = 0;
        while (!fl_if.init_done && cycles < 100) begin
            step();
            cycles++;
        end
        chk(tag, cycles, exp_cycles);
    endtask
`endif

    initial begin
        idle();
        #2;
        chk("rst_count", int'(fl_if.count), 0);
        chk("rst_full", int'(fl_if.full), 0);
        chk("rst_pop_valid", int'(fl_if.pop_valid), 0);
`ifdef FREE_LIST_INIT_EN
        chk("rst_init_done", int'(fl_if.init_done), 0);
        step();
        rst = 1'b0;
        wait_init("init_cycles", 16);
        chk("init_count", int'(fl_if.count), 32);
        chk("init_full", int'(fl_if.full), 1);
        chk("init_pop0", slice(0), 32);
        chk("init_pop1", slice(1), 33);

        for (int i = 0; i < 3; i++) begin
            fl_if.pop_request = 2'b11;
            chk("dual_pop0", slice(0), 32 + 2*i);
            chk("dual_pop1", slice(1), 33 + 2*i);
            step();
        end
        idle();
        chk("dual_count", int'(fl_if.count), 26);
        chk("dual_full", int'(fl_if.full), 0);
        fl_if.rollback_count = 2'd2;
        step();
        idle();
        chk("rb_count", int'(fl_if.count), 28);
        chk("rb_pop0", slice(0), 36);
        chk("rb_pop1", slice(1), 37);

        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("midinit_init_done", int'(fl_if.init_done), 0);
        chk("midinit_count", int'(fl_if.count), 0);
        chk("midinit_pop_valid", int'(fl_if.pop_valid), 0);
        step();
        rst = 1'b0;
        wait_init("reinit_cycles", 16);
        chk("reinit_count", int'(fl_if.count), 32);
        chk("reinit_pop0", slice(0), 32);
`else
        chk("rst_init_done", int'(fl_if.init_done), 1);
        step();
        rst = 1'b0;

        // Sparse push compaction
        drive_push(2'b10, 63, 9);
        step();
        chk("sparse1_count", int'(fl_if.count), 1);
        chk("sparse1_valid", int'(fl_if.pop_valid), 1);
        drive_push(2'b11, 4, 5);
        step();
        idle();
        chk("sparse_count", int'(fl_if.count), 3);
        chk("sparse_pop0", slice(0), 9);
        chk("sparse_pop1", slice(1), 4);
        chk("sparse_valid", int'(fl_if.pop_valid), 3);

        // Pop two, leaving count = 1 with 5 at the head
        fl_if.pop_request = 2'b11;
        step();
        idle();
        chk("pop2_count", int'(fl_if.count), 1);
        chk("pop2_head", slice(0), 5);
        chk("pop2_valid", int'(fl_if.pop_valid), 1);

        // Pop 1 + push 2 + rollback 1 in one cycle: read index unchanged
        fl_if.pop_request    = 2'b01;
        fl_if.rollback_count = 2'd1;
        drive_push(2'b11, 20, 21);
        step();
        idle();
        chk("simul_count", int'(fl_if.count), 3);
        chk("simul_pop0", slice(0), 5);
        chk("simul_pop1", slice(1), 20);

        // Dual pop then rollback of both
        fl_if.pop_request = 2'b11;
        step();
        idle();
        chk("dual_count", int'(fl_if.count), 1);
        chk("dual_head", slice(0), 21);
        fl_if.rollback_count = 2'd2;
        step();
        idle();
        chk("rb_count", int'(fl_if.count), 3);
        chk("rb_pop0", slice(0), 5);
        chk("rb_pop1", slice(1), 20);

        // Drain to empty
        fl_if.pop_request = 2'b11;
        step();
        fl_if.pop_request = 2'b01;
        step();
        idle();
        chk("drain_count", int'(fl_if.count), 0);
        chk("drain_valid", int'(fl_if.pop_valid), 0);

        // Wrap-around: 1 push + 1 pop per cycle across the index wrap
        drive_push(2'b01, 10, 0);
        step();
        for (int i = 0; i < 40; i++) begin
            fl_if.pop_request = 2'b01;
            drive_push(2'b01, 11 + i, 0);
            chk("wrap_data", slice(0), 10 + i);
            step();
        end
        idle();
        chk("wrap_count", int'(fl_if.count), 1);
        chk("wrap_last", slice(0), 50);

        // Fill to full from empty
        fl_if.pop_request = 2'b01;
        step();
        idle();
        for (int j = 0; j < 16; j++) begin
            drive_push(2'b11, 2*j, 2*j + 1);
            step();
        end
        idle();
        chk("fill_count", int'(fl_if.count), 32);
        chk("fill_full", int'(fl_if.full), 1);
        chk("fill_pop0", slice(0), 0);
        chk("fill_pop1", slice(1), 1);
        fl_if.pop_request = 2'b11;
        step();
        idle();
        chk("unfull_count", int'(fl_if.count), 30);
        chk("unfull_full", int'(fl_if.full), 0);
        chk("unfull_head", slice(0), 2);

        // Async reset mid-operation with a push in flight
        drive_push(2'b11, 7, 8);
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", int'(fl_if.count), 0);
        chk("midrst_full", int'(fl_if.full), 0);
        chk("midrst_valid", int'(fl_if.pop_valid), 0);
        step();
        idle();
        rst = 1'b0;
        step();
        chk("postrst_count", int'(fl_if.count), 0);
        chk("postrst_init_done", int'(fl_if.init_done), 1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
